// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared instruction layout and FSM encoding for the issue stage
package pipeline_pkg;

    localparam int INSTR_W  = 24;

    localparam int FUNC_HI  = 23;
    localparam int FUNC_LO  = 20;
    localparam int RD_HI    = 19;
    localparam int RD_LO    = 16;
    localparam int RS1_HI   = 15;
    localparam int RS1_LO   = 12;
    localparam int RS2_HI   = 11;
    localparam int RS2_LO   = 8;
    localparam int ADDR_HI  = 7;
    localparam int ADDR_LO  = 0;

    localparam int FUNC_MAX = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RAW hazard window of recently issued destination registers
module issue_scoreboard #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_valid,
    input  logic [3:0] push_rd,
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    output logic       hazard,
    output logic       empty
);

    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [DEPTH-1:0][3:0] rd_q, rd_d;

    // Shift every cycle; a non-issuing cycle pushes an invalid slot so entries age out
    always_comb begin
        vld_d    = '0;
        rd_d     = '0;
        vld_d[0] = push_valid;
        rd_d[0]  = push_valid ? push_rd : 4'd0;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
    end

    // Window register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            rd_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
        end
    end

    // Either source operand matching any live destination blocks the reader
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && ((rd_q[i] == rs1) || (rd_q[i] == rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    assign empty = ~|vld_q;

endmodule

// File: rtl/pipeline_issue_unit.sv
// rtl/pipeline_issue_unit.sv - program memory, fetch/decode and hazard-aware issue FSM
module pipeline_issue_unit #(
    parameter int PROG_AW    = 4,
    parameter int HAZ_WINDOW = 2,
    parameter int FUNC_MAX   = pipeline_pkg::FUNC_MAX
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_waddr,
    input  logic [23:0]        prog_wdata,
    input  logic               start,
    input  logic [PROG_AW-1:0] last_pc,
    input  logic               issue_ready,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [3:0]         rd,
    output logic [3:0]         func,
    output logic [7:0]         addr,
    output logic               issue_valid,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    import pipeline_pkg::*;

    logic [INSTR_W-1:0] mem [2**PROG_AW];
    logic [INSTR_W-1:0] instr_q;

    state_e             state_q, state_d;
    logic [PROG_AW-1:0] pc_q, pc_d;
    logic [PROG_AW-1:0] last_pc_q, last_pc_d;
    logic               illegal_q, illegal_d;
    logic               issue_valid_q, issue_valid_d;
    logic [3:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, func_q, func_d;
    logic [7:0]         addr_q, addr_d;

    logic [3:0]         dec_func, dec_rd, dec_rs1, dec_rs2;
    logic [7:0]         dec_addr;
    logic               push_valid, advance, hazard, sb_empty;

    assign dec_func = instr_q[FUNC_HI:FUNC_LO];
    assign dec_rd   = instr_q[RD_HI:RD_LO];
    assign dec_rs1  = instr_q[RS1_HI:RS1_LO];
    assign dec_rs2  = instr_q[RS2_HI:RS2_LO];
    assign dec_addr = instr_q[ADDR_HI:ADDR_LO];

    // Host write port and fetch read port; a same-address collision reads the old word
    always_ff @(posedge clk1) begin
        if (prog_we) begin
            mem[prog_waddr] <= prog_wdata;
        end
        if (state_q == FETCH) begin
            instr_q <= mem[pc_q];
        end
    end

    issue_scoreboard #(
        .DEPTH (HAZ_WINDOW)
    ) u_scoreboard (
        .clk        (clk1),
        .rst        (rst),
        .push_valid (push_valid),
        .push_rd    (dec_rd),
        .rs1        (dec_rs1),
        .rs2        (dec_rs2),
        .hazard     (hazard),
        .empty      (sb_empty)
    );

    // Next-state, program counter and issue decision
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        last_pc_d     = last_pc_q;
        illegal_d     = illegal_q;
        issue_valid_d = 1'b0;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        func_d        = func_q;
        addr_d        = addr_q;
        push_valid    = 1'b0;
        advance       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d      = '0;
                    last_pc_d = last_pc;
                    illegal_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                if (int'(dec_func) > FUNC_MAX) begin
                    illegal_d = 1'b1;
                    advance   = 1'b1;
                end else if (!hazard && issue_ready) begin
                    rs1_d         = dec_rs1;
                    rs2_d         = dec_rs2;
                    rd_d          = dec_rd;
                    func_d        = dec_func;
                    addr_d        = dec_addr;
                    issue_valid_d = 1'b1;
                    push_valid    = 1'b1;
                    advance       = 1'b1;
                end
                // Final slot drains instead of incrementing, so pc never wraps in a run
                if (advance) begin
                    if (pc_q == last_pc_q) begin
                        state_d = DRAIN;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (sb_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            last_pc_q     <= '0;
            illegal_q     <= 1'b0;
            issue_valid_q <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            func_q        <= '0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            last_pc_q     <= last_pc_d;
            illegal_q     <= illegal_d;
            issue_valid_q <= issue_valid_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            func_q        <= func_d;
            addr_q        <= addr_d;
        end
    end

    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign func        = func_q;
    assign addr        = addr_q;
    assign issue_valid = issue_valid_q;
    assign illegal     = illegal_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule
